spi_slave_transceiver: RTL
==========================

# spi_slave_transceiver

Word-oriented SPI slave (target) endpoint, the far end of the team's SPI master transceiver. It samples the external SCLK, CS_n and MOSI pins in the system clock domain and shifts WIDTH-bit words in and out, MSB first, in any of the four CPOL/CPHA modes. It exposes the same single-word tx/rx buffer and flag handshake as the master, so the same controller logic can drive either end.

## Interface
- WIDTH, 8, transaction word width in bits (≥ 2)
- SYNC_STAGES, 2, synchronizer flops per input pin (≥ 2)

- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- tx_data  input  WIDTH  word to transmit on MISO
- rx_data  output  WIDTH  last complete received word (rx_buf)
- wr_en  input  1  write tx_data into tx_buf, set tx_not_empty
- read  input  1  acknowledge rx_buf, clear rx_not_empty
- mode  input  2  {CPOL, CPHA}; only changed while deselected
- tx_not_empty  output  1  tx_buf holds a word not yet loaded
- rx_not_empty  output  1  rx_buf holds an unread word
- request  output  1  one-cycle pulse per completed word
- selected  output  1  synchronized CS active (CS_n low)
- spi_clk  input  1  SCLK from master
- spi_cs_n  input  1  chip select from master, active-low
- spi_data_in  input  1  MOSI
- spi_data_out  output  1  MISO
- spi_data_oe  output  1  MISO output enable (= selected)

## Operation
- Every pin passes through SYNC_STAGES flops, then one edge-detect flop; all logic uses synchronized copies.
- Leading edge = SCLK leaving CPOL level; trailing = returning. Sample edge = leading if CPHA=0 else trailing; shift edge = the other.
- FSM: IDLE (cs_n_s high) -> ACTIVE on cs_n_s fall; ACTIVE -> IDLE on cs_n_s rise. Edges are ignored in IDLE.
- Load: on IDLE->ACTIVE and on any shift edge with bit_cnt==0, tx_sh <= tx_buf if tx_not_empty else all-zero; tx_not_empty clears on load.
- Shift edge with bit_cnt≠0: tx_sh <= tx_sh << 1. spi_data_out = tx_sh[WIDTH-1] while selected, else 0.
- Sample edge: rx_sh <= {rx_sh[WIDTH-2:0], mosi_s}; bit_cnt +1. On bit_cnt==WIDTH-1: rx_buf <= {rx_sh[WIDTH-2:0], mosi_s}, rx_not_empty set, request pulses, bit_cnt wraps to 0.
- bit_cnt width = $clog2(WIDTH); wrap is explicit at WIDTH-1, not natural overflow.
- Simultaneous: wr_en with load -> load uses old tx_buf, tx_not_empty stays 1 (new word queued). read with word completion -> rx_not_empty stays 1, rx_buf updated.
- Overwrite: completion with rx_not_empty=1 overwrites rx_buf.
- CS rise mid-word: bit_cnt <= 0, partial rx_sh discarded, rx_buf/rx_not_empty unchanged, no request; the loaded tx word is lost.
- Reset: all outputs 0 (rx_data, flags, request, selected, spi_data_out, spi_data_oe); FSM IDLE; synchronizers reset to spi_cs_n=1, spi_clk=0.

## Timing
- Pin edge to internal action: SYNC_STAGES+1 clk (3 at default).
- Requirement on master: SCLK half-period ≥ 4 clk (clk ≥ 8× SCLK); CS_n fall to first SCLK edge ≥ 4 clk.
- MISO changes SYNC_STAGES+2 clk after the pin shift edge.
- request, rx_not_empty set and rx_data update in the same clk, 1 clk after the final synchronized sample edge.
- tx_not_empty/rx_not_empty respond to wr_en/read on the next clk edge.

## Configuration
- SPI_SLAVE_OVERRUN_EN defined: adds output overrun (1 bit, reset 0), set when a word completes while rx_not_empty=1, cleared by read (set wins if coincident).
- Undefined: port absent; overwrite is silent.

## Test plan
- Mode 0, WIDTH=8: wr_en 0xA5, master sends 0x3C -> MISO 0xA5, rx_data=0x3C, one request pulse, rx_not_empty=1, tx_not_empty=0.
- Modes 1, 2, 3: same exchange -> identical results; MISO stable across every sample edge.
- Back-to-back: 0x11 queued, then 0x22 written mid-word 1; master sends 0xF0,0x0F under one CS -> MISO 0x11,0x22; two requests; rx_data ends 0x0F.
- Underrun/overwrite: no wr_en, two words 0x81,0x42 without read -> MISO 0x00,0x00; rx_data=0x42; overrun=1 if macro defined.
- CS rise after 5 bits -> no request, rx_not_empty unchanged, next CS restarts at bit 0.
- rst_n low mid-word -> all outputs 0 immediately, FSM IDLE; post-reset full exchange succeeds.

Source files
------------

// File: rtl/spi_slave_transceiver.sv
// spi_slave_transceiver: word-oriented SPI target with CPOL/CPHA modes, tx/rx single-word buffers and flags.
// Optional SPI_SLAVE_OVERRUN_EN adds o_overrun, flagging a word completed while rx_buf was still unread.
module spi_slave_transceiver #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_tx_data,
   output logic [WIDTH-1:0] o_rx_data,
   input  logic             i_wr_en,
   input  logic             i_read,
   input  logic [1:0]       i_mode,
   output logic             o_tx_not_empty,
   output logic             o_rx_not_empty,
   output logic             o_request,
   output logic             o_selected,
`ifdef SPI_SLAVE_OVERRUN_EN
   output logic             o_overrun,
`endif
   input  logic             i_spi_clk,
   input  logic             i_spi_cs_n,
   input  logic             i_spi_data_in,
   output logic             o_spi_data_out,
   output logic             o_spi_data_oe
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;
   state_t r_state, w_state_next;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
   logic                   r_sclk_d, r_cs_d;
   logic [WIDTH-1:0]       r_tx_buf, r_tx_sh, r_rx_sh, r_rx_buf;
   logic [CW-1:0]          r_bit_cnt;
   logic                   r_tne, r_rne, r_req, r_fresh, r_miso_q, r_ovr;

   logic w_sclk, w_cs_n, w_mosi, w_cpol, w_cpha, w_lead, w_trail, w_act;
   logic w_sample, w_shift, w_start, w_load, w_done;
   logic [WIDTH-1:0] w_rx_word;

   assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n    = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
   assign w_cpol    = i_mode[1];
   assign w_cpha    = i_mode[0];
   assign w_lead    = (r_sclk_d == w_cpol) && (w_sclk != w_cpol);
   assign w_trail   = (r_sclk_d != w_cpol) && (w_sclk == w_cpol);
   assign w_act     = (r_state == S_ACTIVE) && !w_cs_n;
   assign w_sample  = w_act && (w_cpha ? w_trail : w_lead);
   assign w_shift   = w_act && (w_cpha ? w_lead : w_trail);
   assign w_start   = (r_state == S_IDLE) && r_cs_d && !w_cs_n;
   // r_fresh stops the first CPHA=1 shift edge from reloading over the word loaded at select
   assign w_load    = w_start || (w_shift && r_bit_cnt == '0 && !r_fresh);
   assign w_done    = w_sample && (r_bit_cnt == LAST);
   assign w_rx_word = {r_rx_sh[WIDTH-2:0], w_mosi};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (r_state == S_IDLE && w_start) w_state_next = S_ACTIVE;
      if (r_state == S_ACTIVE && w_cs_n) w_state_next = S_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_sclk_d    <= 1'b0;
         r_cs_d      <= 1'b1;
         r_tx_buf    <= '0;
         r_tx_sh     <= '0;
         r_rx_sh     <= '0;
         r_rx_buf    <= '0;
         r_bit_cnt   <= '0;
         r_tne       <= 1'b0;
         r_rne       <= 1'b0;
         r_req       <= 1'b0;
         r_fresh     <= 1'b0;
         r_miso_q    <= 1'b0;
         r_ovr       <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_clk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_data_in};
         r_sclk_d    <= w_sclk;
         r_cs_d      <= w_cs_n;
         if (i_wr_en) begin
            r_tx_buf <= i_tx_data;
            r_tne    <= 1'b1;
         end else if (w_load) begin
            r_tne    <= 1'b0;
         end
         if (w_load)                             r_tx_sh <= r_tne ? r_tx_buf : '0;
         else if (w_shift && r_bit_cnt != '0)    r_tx_sh <= r_tx_sh << 1;
         r_fresh  <= w_start ? 1'b1 : (w_shift ? 1'b0 : r_fresh);
         r_miso_q <= r_tx_sh[WIDTH-1];
         if (!w_act)        r_bit_cnt <= '0;
         else if (w_sample) r_bit_cnt <= w_done ? '0 : r_bit_cnt + 1'b1;
         if (w_sample) r_rx_sh  <= w_rx_word;
         if (w_done)   r_rx_buf <= w_rx_word;
         r_req <= w_done;
         r_rne <= w_done | (r_rne & ~i_read);
         r_ovr <= (w_done & r_rne) | (r_ovr & ~i_read);
      end
   end

   assign o_rx_data      = r_rx_buf;
   assign o_tx_not_empty = r_tne;
   assign o_rx_not_empty = r_rne;
   assign o_request      = r_req;
   assign o_selected     = (r_state == S_ACTIVE);
   assign o_spi_data_oe  = o_selected;
   assign o_spi_data_out = o_selected & r_miso_q;
`ifdef SPI_SLAVE_OVERRUN_EN
   assign o_overrun      = r_ovr;
`else
   logic w_ovr_unused;
   assign w_ovr_unused   = r_ovr;
`endif
endmodule
